// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: default frame geometry (common to
//               uart_tx and uart_rx) and the receiver state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Default frame geometry, shared by uart_tx and uart_rx.
    localparam int c_d_w_default    = 8;
    localparam int c_b_tick_default = 16;

    // Receiver states, explicit 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for a single asynchronous input.
//               Both flops load RST_VAL on reset so the synchronized output
//               shows the input's inactive level straight out of reset.
// Ports       : clk      - destination clock
//               rst      - asynchronous active-high reset
//               i_async  - asynchronous input
//               o_sync   - input synchronized to clk (2 clk latency)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : UART receiver. 1 start bit, D_W data bits LSB first, 1 stop
//               bit, oversampled at B_TICK baud ticks per bit and sampled
//               mid-bit. Each frame is presented with a one-cycle rx_done
//               strobe and a framing-error flag (stop bit sampled low).
// Ports       : clk         - system clock
//               rst         - asynchronous active-high reset
//               baud_clk    - one-clk tick from baud_gen, B_TICK per bit
//               rx_data     - serial line, idle high, asynchronous to clk
//               baud_en     - enable request to the local baud_gen
//               output_data - last received byte (held until next rx_done)
//               rx_done     - one-cycle strobe, output_data valid
//               frame_err   - stop bit of the last frame sampled low
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int D_W    = c_d_w_default,
    parameter int B_TICK = c_b_tick_default
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           baud_clk,
    input  logic           rx_data,
    output logic           baud_en,
    output logic [D_W-1:0] output_data,
    output logic           rx_done,
    output logic           frame_err
);

    localparam int c_s_w = (B_TICK > 1) ? $clog2(B_TICK) : 1;
    localparam int c_n_w = (D_W > 1)    ? $clog2(D_W)    : 1;

    // Tick counts at which the FSM acts: mid start bit, then one full bit
    // period for every subsequent sample.
    localparam logic [c_s_w-1:0] c_s_half = c_s_w'(B_TICK / 2 - 1);
    localparam logic [c_s_w-1:0] c_s_last = c_s_w'(B_TICK - 1);
    localparam logic [c_n_w-1:0] c_n_last = c_n_w'(D_W - 1);
    localparam logic [c_s_w-1:0] c_s_one  = c_s_w'(1);
    localparam logic [c_n_w-1:0] c_n_one  = c_n_w'(1);

    logic w_rx_s;

    rx_state_t        r_state, w_state_nx;
    logic [c_s_w-1:0] r_s,     w_s_nx;
    logic [c_n_w-1:0] r_n,     w_n_nx;
    logic [D_W-1:0]   r_shreg, w_shreg_nx;
    logic [D_W-1:0]   r_data,  w_data_nx;
    logic             r_ferr,  w_ferr_nx;
    logic             r_done,  w_done_nx;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync_rx (
        .clk     (clk),
        .rst     (rst),
        .i_async (rx_data),
        .o_sync  (w_rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_shreg <= '0;
            r_data  <= '0;
            r_ferr  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_s     <= w_s_nx;
            r_n     <= w_n_nx;
            r_shreg <= w_shreg_nx;
            r_data  <= w_data_nx;
            r_ferr  <= w_ferr_nx;
            r_done  <= w_done_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_s_nx     = r_s;
        w_n_nx     = r_n;
        w_shreg_nx = r_shreg;
        w_data_nx  = r_data;
        w_ferr_nx  = r_ferr;
        w_done_nx  = 1'b0;

        case (r_state)
            IDLE: begin
                // Ticks are ignored here; only a low line starts a frame.
                w_s_nx = '0;
                w_n_nx = '0;
                if (!w_rx_s) begin
                    w_state_nx = START;
                end
            end

            START: begin
                if (baud_clk) begin
                    if (r_s == c_s_half) begin
                        w_s_nx = '0;
                        // Line back high at mid start bit: glitch, drop it
                        // without touching the delivered outputs.
                        w_state_nx = w_rx_s ? IDLE : DATA;
                    end else begin
                        w_s_nx = r_s + c_s_one;
                    end
                end
            end

            DATA: begin
                if (baud_clk) begin
                    if (r_s == c_s_last) begin
                        w_s_nx     = '0;
                        w_shreg_nx = {w_rx_s, r_shreg[D_W-1:1]};
                        if (r_n == c_n_last) begin
                            w_n_nx     = '0;
                            w_state_nx = STOP;
                        end else begin
                            w_n_nx = r_n + c_n_one;
                        end
                    end else begin
                        w_s_nx = r_s + c_s_one;
                    end
                end
            end

            STOP: begin
                if (baud_clk) begin
                    if (r_s == c_s_last) begin
                        // A bad stop bit still delivers the byte, flagged.
                        w_s_nx     = '0;
                        w_data_nx  = r_shreg;
                        w_ferr_nx  = ~w_rx_s;
                        w_done_nx  = 1'b1;
                        w_state_nx = IDLE;
                    end else begin
                        w_s_nx = r_s + c_s_one;
                    end
                end
            end

            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // Decoded from the state register so baud_en rises the cycle after the
    // start edge is seen and falls the cycle the FSM is back in IDLE.
    assign baud_en     = (r_state != IDLE);
    assign output_data = r_data;
    assign rx_done     = r_done;
    assign frame_err   = r_ferr;

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx. A local divider produces
//               baud_clk; frames are bit-banged onto rx_data and received
//               bytes are collected by a monitor into a queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int D_W     = 8;
    localparam int B_TICK  = 16;
    localparam int DIV     = 4;
    localparam int BIT_CLK = B_TICK * DIV;

    logic           clk      = 1'b0;
    logic           rst      = 1'b0;
    logic           baud_clk = 1'b0;
    logic           rx_data  = 1'b1;
    logic           baud_en;
    logic [D_W-1:0] output_data;
    logic           rx_done;
    logic           frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    int div_cnt = 0;

    logic [D_W:0] rxq[$];

    uart_rx #(
        .D_W    (D_W),
        .B_TICK (B_TICK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .baud_clk    (baud_clk),
        .rx_data     (rx_data),
        .baud_en     (baud_en),
        .output_data (output_data),
        .rx_done     (rx_done),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    // Free-running baud tick: one clk high every DIV clocks.
    always @(posedge clk) begin
        if (div_cnt == DIV - 1) begin
            div_cnt  <= 0;
            baud_clk <= 1'b1;
        end else begin
            div_cnt  <= div_cnt + 1;
            baud_clk <= 1'b0;
        end
    end

    // Record every completed frame as {frame_err, output_data}.
    always @(negedge clk) begin
        if (rx_done === 1'b1) begin
            rxq.push_back({frame_err, output_data});
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int clks);
        rx_data = b;
        wait_clk(clks);
    endtask

    // Bad stop: line held low just past the stop sample point, then high,
    // so the receiver's re-armed start detector rejects it as a glitch.
    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        send_bit(1'b0, BIT_CLK);
        for (int i = 0; i < D_W; i++) begin
            send_bit(d[i], BIT_CLK);
        end
        if (stop_ok) begin
            send_bit(1'b1, BIT_CLK);
        end else begin
            send_bit(1'b0, BIT_CLK / 2 + BIT_CLK / 8);
            send_bit(1'b1, BIT_CLK - (BIT_CLK / 2 + BIT_CLK / 8));
        end
    endtask

    task automatic expect_frame(input string nm, input logic [7:0] ed, input logic ef);
        logic [D_W:0] v;
        check({nm, " done_count"}, rxq.size(), 1);
        if (rxq.size() > 0) begin
            v = rxq.pop_front();
            check({nm, " data"}, v[D_W-1:0], ed);
            check({nm, " ferr"}, v[D_W], ef);
        end
        rxq.delete();
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop_ok;
        logic [7:0] exp_d;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{8'h55, 1'b1, 8'h55, 1'b0};
        vecs[1] = '{8'hA3, 1'b1, 8'hA3, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 8'h3C, 1'b1};
        vecs[3] = '{8'h01, 1'b1, 8'h01, 1'b0};
        vecs[4] = '{8'h80, 1'b1, 8'h80, 1'b0};

        // Reset state
        #1 rst = 1'b1;
        wait_clk(4);
        check("rst output_data", output_data, 0);
        check("rst rx_done", rx_done, 0);
        check("rst frame_err", frame_err, 0);
        check("rst baud_en", baud_en, 0);
        rst = 1'b0;
        wait_clk(BIT_CLK);
        check("idle baud_en", baud_en, 0);

        // Table-driven frames
        foreach (vecs[k]) begin
            send_frame(vecs[k].d, vecs[k].stop_ok);
            send_bit(1'b1, BIT_CLK);
            expect_frame($sformatf("vec%0d", k), vecs[k].exp_d, vecs[k].exp_ferr);
            check($sformatf("vec%0d held_data", k), output_data, vecs[k].exp_d);
            check($sformatf("vec%0d held_ferr", k), frame_err, vecs[k].exp_ferr);
            check($sformatf("vec%0d baud_en", k), baud_en, 0);
        end

        // Glitch: low for 3 ticks, then high
        send_bit(1'b0, 3 * DIV);
        check("glitch baud_en_rise", baud_en, 1);
        send_bit(1'b1, BIT_CLK);
        check("glitch no_done", rxq.size(), 0);
        check("glitch baud_en", baud_en, 0);
        check("glitch data_kept", output_data, 8'h80);
        check("glitch ferr_kept", frame_err, 0);

        // Reset in the middle of data bit 4 of 8'hC7 (bits LSB first: 1,1,1,0,0)
        send_bit(1'b0, BIT_CLK);
        send_bit(1'b1, BIT_CLK);
        send_bit(1'b1, BIT_CLK);
        send_bit(1'b1, BIT_CLK);
        send_bit(1'b0, BIT_CLK);
        send_bit(1'b0, BIT_CLK / 2);
        check("midrst baud_en_before", baud_en, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst output_data", output_data, 0);
        check("midrst frame_err", frame_err, 0);
        check("midrst rx_done", rx_done, 0);
        check("midrst baud_en", baud_en, 0);
        rx_data = 1'b1;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(2 * BIT_CLK);
        check("midrst no_done", rxq.size(), 0);
        send_frame(8'hC7, 1'b1);
        send_bit(1'b1, BIT_CLK);
        expect_frame("after_rst", 8'hC7, 1'b0);

        // Back-to-back frames, zero idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_bit(1'b1, BIT_CLK);
        check("b2b done_count", rxq.size(), 2);
        if (rxq.size() == 2) begin
            check("b2b first_data", rxq[0][D_W-1:0], 8'h00);
            check("b2b first_ferr", rxq[0][D_W], 0);
            check("b2b second_data", rxq[1][D_W-1:0], 8'hFF);
            check("b2b second_ferr", rxq[1][D_W], 0);
        end
        rxq.delete();
        check("b2b baud_en", baud_en, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_uart_rx
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver. Counterpart to uart_tx; shares the same baud_gen tick source.
- Recovers frames from the serial line: 1 start bit, D_W data bits LSB first, 1 stop bit.
- Oversamples at B_TICK ticks per bit, samples mid-bit, and presents each received byte with a one-cycle done strobe and a framing-error flag.
- Sits between the pad-side rx line and the host/FIFO logic; drives baud_en to gate its own baud_gen instance.

Parameters:
- D_W, 8, data bits per frame
- B_TICK, 16, baud_clk ticks per bit period (must be even, >= 4)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- baud_clk  input  1  one-clk-wide tick from baud_gen, B_TICK per bit
- rx_data  input  1  serial line, idle high, asynchronous to clk
- baud_en  output  1  enable request to baud_gen
- output_data  output  D_W  last received byte
- rx_done  output  1  one-cycle strobe: frame complete, output_data valid
- frame_err  output  1  stop bit sampled low on the last frame

Behaviour:
- Reset (async, rst=1): all outputs 0, state IDLE, counters 0, synchronizer flops set to 1 (line idle). Leaving reset needs no sync beyond the clk edge.
- Input conditioning: rx_data passes through a 2-flop synchronizer. All decisions use the synchronized value rx_s, giving 2 clk of latency.
- Counters: sample counter s of width clog2(B_TICK); bit counter n of width clog2(D_W). Both advance only on cycles with baud_clk=1.
- IDLE: baud_en=0, s=0, n=0. When rx_s=0 (falling edge seen), go to START and assert baud_en from the next cycle.
- START: on each tick, s++. When s==B_TICK/2-1 on a tick:
  - if rx_s=0: s<=0, go to DATA (now aligned mid start bit).
  - if rx_s=1: false start/glitch; go to IDLE with no strobe and no output change.
- DATA: on each tick, s++. When s==B_TICK-1 on a tick:
  - shift register <= {rx_s, shreg[D_W-1:1]} (LSB first), s<=0.
  - if n==D_W-1, go to STOP; else n++.
- STOP: on each tick, s++. When s==B_TICK-1 on a tick (mid stop bit):
  - output_data<=shreg, frame_err<=~rx_s, rx_done<=1 for exactly one clk.
  - go to IDLE. baud_en drops in the same cycle the state becomes IDLE.
- Data delivery and holds:
  - A frame with a bad stop bit is still delivered (rx_done=1, frame_err=1).
  - output_data and frame_err hold until the next rx_done.
- Next frame: detection of the next start bit begins in IDLE one clk after rx_done. This tolerates a back-to-back frame whose start edge arrives up to half a bit after the stop sample.
- baud_clk asserted while in IDLE is ignored.
- rx_s transitions between ticks are ignored; only tick-cycle samples matter.
- Reset mid-frame: immediate abort to IDLE. The partial byte is discarded; no rx_done.

Decomposition:
- Package uart_pkg holds:
  - the rx state enum (IDLE, START, DATA, STOP) as a 2-bit typedef
  - default D_W/B_TICK constants, shared with uart_tx
- Sub-module sync_2ff: 2-flop synchronizer with reset value parameter RST_VAL=1. Reusable on other async inputs.
- The FSM and datapath stay in uart_rx.

Test Plan:
- Loopback: uart_tx -> uart_rx via baud_gen, dvsr=54, 100MHz clk; send 8'h55 -> exactly one rx_done pulse, output_data=8'h55, frame_err=0.
- Bit-banged 8'hA3 at B_TICK*(dvsr+1) clk per bit, stop=1 -> output_data=8'hA3, frame_err=0, baud_en=0 after rx_done.
- Glitch: rx_data low for 3 ticks then high -> no rx_done, FSM back in IDLE, output_data unchanged from the previous value.
- Framing error: send 8'h3C with the stop bit held 0 -> rx_done=1, output_data=8'h3C, frame_err=1. A following good frame 8'h01 -> frame_err=0.
- Reset mid-frame: assert rst during DATA bit 4 -> outputs 0 immediately, no rx_done. After release, frame 8'hC7 -> output_data=8'hC7.
- Back-to-back frames 8'h00 then 8'hFF with zero idle gap -> two rx_done pulses, values 8'h00 then 8'hFF, frame_err=0 both times.
